lsu_agen_rx_queue: RTL and testbench

//  LSU-side receiver for the AGEN->LSU packet stream. Buffers address-generated
//  ld/st packets in a small circular FIFO while the LSU is busy (cache miss, LSQ

---
 rtl/lsu_agen_rx_queue.sv | 109 ++++++++++
 tb/tb_lsu_agen_rx_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_agen_rx_queue.sv
// AGEN->LSU receive queue: circular buffer of ld/st packets with
// branch-mask squash on mispredict and mask clearing on verify.
module lsu_agen_rx_queue #(
    parameter int DEPTH        = 4,
    parameter int MASK_W       = 8,
    parameter int MASK_LOG     = 3,
    parameter int PAYLOAD_W    = 96,
    parameter int STALL_THRESH = 2,
    localparam int PKT_W       = MASK_W + PAYLOAD_W,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                agenPacketValid_i,
    input  logic [PKT_W-1:0]    agenPacket_i,
    input  logic                ctrlMispredict_i,
    input  logic [MASK_LOG-1:0] ctrlSMTid_i,
    input  logic                ctrlVerified_i,
    input  logic [MASK_LOG-1:0] ctrlVerifyId_i,
    input  logic                lsuReady_i,
    output logic                lsuPacketValid_o,
    output logic [PKT_W-1:0]    lsuPacket_o,
    output logic                stall_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                overflow_o
);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - STALL_THRESH);

    logic                 slotVld     [DEPTH];
    logic [MASK_W-1:0]    slotMask    [DEPTH];
    logic [PAYLOAD_W-1:0] slotPayload [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] nextCount;

    logic             countNz;
    logic             full;
    logic             headSquash;
    logic             pop;
    logic             push;
    logic [MASK_W-1:0] inMask;
    logic [MASK_W-1:0] wrMask;
    logic             wrVld;

    always_comb begin
        countNz          = (count != '0);
        full             = (count == FULL_CNT);
        headSquash       = ctrlMispredict_i & slotMask[head][ctrlSMTid_i];
        lsuPacketValid_o = countNz & slotVld[head] & ~headSquash;
        lsuPacket_o      = {slotMask[head], slotPayload[head]};
        // Bubbles and freshly squashed heads leave without a handshake
        pop  = (lsuPacketValid_o & lsuReady_i) | (countNz & ~lsuPacketValid_o);
        push = agenPacketValid_i & (~full | pop);
        inMask = agenPacket_i[PKT_W-1 -: MASK_W];
        wrMask = inMask;
        if (ctrlVerified_i) begin
            wrMask[ctrlVerifyId_i] = 1'b0;
        end
        wrVld     = ~(ctrlMispredict_i & inMask[ctrlSMTid_i]);
        nextCount = count + CNT_W'(push) - CNT_W'(pop);
    end

    assign count_o = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            stall_o    <= 1'b0;
            overflow_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slotVld[i]     <= 1'b0;
                slotMask[i]    <= '0;
                slotPayload[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ctrlMispredict_i && slotMask[i][ctrlSMTid_i]) begin
                    slotVld[i] <= 1'b0;
                end
                if (ctrlVerified_i) begin
                    slotMask[i][ctrlVerifyId_i] <= 1'b0;
                end
            end
            // The tail write lands last so it overrides the broadcast above
            if (push) begin
                slotVld[tail]     <= wrVld;
                slotMask[tail]    <= wrMask;
                slotPayload[tail] <= agenPacket_i[PAYLOAD_W-1:0];
                tail              <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count   <= nextCount;
            stall_o <= (nextCount >= STALL_CNT);
            if (agenPacketValid_i && full && !pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_agen_rx_queue.sv
// Bench for lsu_agen_rx_queue: vector table for fill/overflow/drain
// plus directed squash/verify/reset sequences, packets checked in order.
module tb_lsu_agen_rx_queue;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         agenPacketValid_i = 1'b0;
    logic [103:0] agenPacket_i = '0;
    logic         ctrlMispredict_i = 1'b0;
    logic [2:0]   ctrlSMTid_i = '0;
    logic         ctrlVerified_i = 1'b0;
    logic [2:0]   ctrlVerifyId_i = '0;
    logic         lsuReady_i = 1'b0;
    logic         lsuPacketValid_o;
    logic [103:0] lsuPacket_o;
    logic         stall_o;
    logic [2:0]   count_o;
    logic         overflow_o;

    int checks = 0;
    int failures = 0;
    logic [103:0] expQ[$];
    logic [103:0] e;

    lsu_agen_rx_queue dut (
        .clk(clk),
        .reset(reset),
        .agenPacketValid_i(agenPacketValid_i),
        .agenPacket_i(agenPacket_i),
        .ctrlMispredict_i(ctrlMispredict_i),
        .ctrlSMTid_i(ctrlSMTid_i),
        .ctrlVerified_i(ctrlVerified_i),
        .ctrlVerifyId_i(ctrlVerifyId_i),
        .lsuReady_i(lsuReady_i),
        .lsuPacketValid_o(lsuPacketValid_o),
        .lsuPacket_o(lsuPacket_o),
        .stall_o(stall_o),
        .count_o(count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  m;
        logic [95:0] p;
        logic        rdy;
        logic        deliver;
        logic [2:0]  cnt;
        logic        stl;
        logic        ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [103:0] got,
                       input logic [103:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] m, input logic [95:0] p,
                         input logic mp, input logic [2:0] sid,
                         input logic ver, input logic [2:0] vid, input logic rdy);
        agenPacketValid_i = v;
        agenPacket_i      = {m, p};
        ctrlMispredict_i  = mp;
        ctrlSMTid_i       = sid;
        ctrlVerified_i    = ver;
        ctrlVerifyId_i    = vid;
        lsuReady_i        = rdy;
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 8'h00, 96'h0, 1'b0, 3'd0, 1'b0, 3'd0, rdy);
    endtask

    task automatic doReset();
        idle(1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chkIdleOuts(input string tag);
        chk({tag, "_count"}, 104'(count_o), 104'd0);
        chk({tag, "_valid"}, 104'(lsuPacketValid_o), 104'd0);
        chk({tag, "_pkt"}, lsuPacket_o, 104'd0);
        chk({tag, "_stall"}, 104'(stall_o), 104'd0);
        chk({tag, "_ovf"}, 104'(overflow_o), 104'd0);
    endtask

    // In-order scoreboard of every packet the LSU actually accepts
    always @(negedge clk) begin
        if (lsuPacketValid_o && lsuReady_i) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pkt got=%0h exp=none", lsuPacket_o);
            end else begin
                e = expQ.pop_front();
                if (lsuPacket_o !== e) begin
                    failures++;
                    $display("FAIL lsu_pkt got=%0h exp=%0h", lsuPacket_o, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h00, 96'h21, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h00, 96'h22, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h00, 96'h23, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'h00, 96'h24, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h00, 96'h25, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 96'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 96'h00, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 96'h00, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 96'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};

        doReset();
        chkIdleOuts("reset");

        // Single packet through an empty queue
        drive(1'b1, 8'h00, 96'hA5, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        expQ.push_back({8'h00, 96'hA5});
        tick();
        idle(1'b1);
        chk("t1_count1", 104'(count_o), 104'd1);
        chk("t1_valid", 104'(lsuPacketValid_o), 104'd1);
        tick();
        chk("t1_count0", 104'(count_o), 104'd0);

        // Fill, overflow, drain
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].m, tbl[i].p, 1'b0, 3'd0, 1'b0, 3'd0, tbl[i].rdy);
            if (tbl[i].deliver) expQ.push_back({tbl[i].m, tbl[i].p});
            tick();
            chk($sformatf("t2_count_%0d", i), 104'(count_o), 104'(tbl[i].cnt));
            chk($sformatf("t2_stall_%0d", i), 104'(stall_o), 104'(tbl[i].stl));
            chk($sformatf("t2_ovf_%0d", i), 104'(overflow_o), 104'(tbl[i].ovf));
        end
        doReset();
        chk("t2_ovf_cleared", 104'(overflow_o), 104'd0);

        // Mispredict id0 turns masks 01 into bubbles
        drive(1'b1, 8'h01, 96'h31, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        drive(1'b1, 8'h02, 96'h32, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        drive(1'b1, 8'h01, 96'h33, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        drive(1'b1, 8'h04, 96'h34, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        expQ.push_back({8'h02, 96'h32});
        expQ.push_back({8'h04, 96'h34});
        chk("t3_full", 104'(count_o), 104'd4);
        drive(1'b0, 8'h00, 96'h0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        chk("t3_head_squash", 104'(lsuPacketValid_o), 104'd0);
        tick();
        chk("t3_count3", 104'(count_o), 104'd3);
        idle(1'b1);
        chk("t3_valid_p1", 104'(lsuPacketValid_o), 104'd1);
        tick();
        chk("t3_count2", 104'(count_o), 104'd2);
        chk("t3_bubble", 104'(lsuPacketValid_o), 104'd0);
        tick();
        chk("t3_count1", 104'(count_o), 104'd1);
        chk("t3_valid_p3", 104'(lsuPacketValid_o), 104'd1);
        tick();
        chk("t3_count0", 104'(count_o), 104'd0);

        // Head squashed in the same cycle it is presented
        drive(1'b1, 8'h04, 96'h44, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        drive(1'b0, 8'h00, 96'h0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
        chk("t4_valid", 104'(lsuPacketValid_o), 104'd0);
        tick();
        idle(1'b0);
        chk("t4_count", 104'(count_o), 104'd0);

        // Verify clears mask bits; verify loses to same-id mispredict
        drive(1'b1, 8'h03, 96'h51, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        drive(1'b1, 8'h03, 96'h52, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        drive(1'b0, 8'h00, 96'h0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0); tick();
        idle(1'b0);
        chk("t5_mask", lsuPacket_o, {8'h01, 96'h51});
        expQ.push_back({8'h01, 96'h51});
        drive(1'b0, 8'h00, 96'h0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1);
        chk("t5_no_squash", 104'(lsuPacketValid_o), 104'd1);
        tick();
        chk("t5_count1", 104'(count_o), 104'd1);
        drive(1'b0, 8'h00, 96'h0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0);
        chk("t5_mp_wins", 104'(lsuPacketValid_o), 104'd0);
        tick();
        idle(1'b0);
        chk("t5_count0", 104'(count_o), 104'd0);

        // Reset mid-operation
        drive(1'b1, 8'h00, 96'h61, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        drive(1'b1, 8'h00, 96'h62, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        drive(1'b1, 8'h00, 96'h63, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); tick();
        idle(1'b0);
        chk("t6_count3", 104'(count_o), 104'd3);
        chk("t6_stall", 104'(stall_o), 104'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chkIdleOuts("t6");

        chk("sb_empty", 104'(expQ.size()), 104'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
